// File: rtl/ppu_soam_buffer.sv
// rtl/ppu_soam_buffer.sv - secondary OAM byte buffer with all-ones clear sweep
// Appends are counted per whole sprite; the clear pass walks the array one address per cycle.
module ppu_soam_buffer #(
  parameter  int SPRITES          = 8,
  parameter  int BYTES_PER_SPRITE = 4,
  parameter  int DATA_W           = 8,
  localparam int DEPTH            = SPRITES * BYTES_PER_SPRITE,
  localparam int AW               = $clog2(DEPTH),
  localparam int CW               = $clog2(SPRITES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_start,
  input  logic              append_valid,
  input  logic [DATA_W-1:0] append_data,
  output logic              append_ready,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [CW-1:0]     sprite_count,
  output logic              full,
  output logic              overflow
);

  localparam int BW = (BYTES_PER_SPRITE > 1) ? $clog2(BYTES_PER_SPRITE) : 1;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_clr_addr;
  logic [AW-1:0]       r_wr_ptr;
  logic [BW-1:0]       r_byte_idx;
  logic [CW-1:0]       r_count;
  logic                r_overflow;
  logic [DATA_W-1:0]   r_rd_data;
  logic                w_clr_we;
  logic                w_app_we;
  logic                w_clr_last;

  assign busy         = (r_state == S_CLEAR);
  assign full         = (r_count == CW'(SPRITES));
  assign sprite_count = r_count;
  assign overflow     = r_overflow;
  assign rd_data      = r_rd_data;
  assign append_ready = !busy && !full && !clear_start;
  assign w_app_we     = append_valid && append_ready;
  assign w_clr_we     = busy;
  assign w_clr_last   = (r_clr_addr == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (clear_start) begin
      w_next_state = S_CLEAR;
    end else if (r_state == S_CLEAR && w_clr_last) begin
      w_next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr_addr <= '0;
      r_wr_ptr   <= '0;
      r_byte_idx <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
      if (clear_start) begin
        r_clr_addr <= '0;
        r_wr_ptr   <= '0;
        r_byte_idx <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (busy) begin
          r_clr_addr <= w_clr_last ? '0 : r_clr_addr + AW'(1);
        end
        if (w_app_we) begin
          // Saturate so the pointer never addresses past the array end.
          if (r_wr_ptr != AW'(DEPTH - 1)) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
          if (r_byte_idx == BW'(BYTES_PER_SPRITE - 1)) begin
            r_byte_idx <= '0;
            r_count    <= r_count + CW'(1);
          end else begin
            r_byte_idx <= r_byte_idx + BW'(1);
          end
        end
        if (append_valid && full && !busy) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset; writes are held off while rst is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_clr_we) begin
        r_mem[r_clr_addr] <= '1;
      end else if (w_app_we) begin
        r_mem[r_wr_ptr] <= append_data;
      end
    end
  end

endmodule

// File: tb/tb_ppu_soam_buffer.sv
// tb/tb_ppu_soam_buffer.sv - directed-vector bench for ppu_soam_buffer
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ppu_soam_buffer;

  logic       clk;
  logic       rst;
  logic       clear_start;
  logic       append_valid;
  logic [7:0] append_data;
  logic       append_ready;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic [3:0] sprite_count;
  logic       full;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  logic [7:0] rv;

  ppu_soam_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .clear_start  (clear_start),
    .append_valid (append_valid),
    .append_data  (append_data),
    .append_ready (append_ready),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .sprite_count (sprite_count),
    .full         (full),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse clear_start, then count busy cycles; optionally poke an append at busy cycle app_at.
  task automatic do_clear(input int app_at, output int cycles);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      if (cycles == app_at) begin
        append_valid = 1'b1;
        append_data  = 8'h33;
        #0;
        chk("ready_in_busy", {31'd0, append_ready}, 32'd0);
      end
      tick();
      append_valid = 1'b0;
    end
  endtask

  task automatic append(input logic [7:0] d);
    append_valid = 1'b1;
    append_data  = d;
    tick();
    append_valid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  initial begin
    rst = 1'b0;
    clear_start = 1'b0;
    append_valid = 1'b0;
    append_data = 8'h00;
    rd_addr = 5'd0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {28'd0, sprite_count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_rdata", {24'd0, rd_data}, 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_ready", {31'd0, append_ready}, 32'd1);

    // Full clear sweep
    do_clear(0, cyc);
    chk("clr_cycles", cyc, 32);
    for (int i = 0; i < 32; i++) begin
      rd(i[4:0], rv);
      chk($sformatf("clr_ff_%0d", i), {24'd0, rv}, 32'h0000_00ff);
    end
    chk("clr_count", {28'd0, sprite_count}, 32'd0);

    // Four sprites
    for (int i = 0; i < 16; i++) append(8'h10 + i[7:0]);
    chk("s4_count", {28'd0, sprite_count}, 32'd4);
    chk("s4_full", {31'd0, full}, 32'd0);
    rd(5'd5, rv);
    chk("s4_rd5", {24'd0, rv}, 32'h15);
    rd(5'd15, rv);
    chk("s4_rd15", {24'd0, rv}, 32'h1f);
    rd(5'd16, rv);
    chk("s4_rd16", {24'd0, rv}, 32'hff);

    // Fill to full, then overflow
    do_clear(0, cyc);
    for (int i = 0; i < 32; i++) append(8'h40 + i[7:0]);
    chk("f_count", {28'd0, sprite_count}, 32'd8);
    chk("f_full", {31'd0, full}, 32'd1);
    chk("f_ready", {31'd0, append_ready}, 32'd0);
    chk("f_ovf0", {31'd0, overflow}, 32'd0);
    append(8'hAA);
    chk("f_ovf1", {31'd0, overflow}, 32'd1);
    chk("f_count2", {28'd0, sprite_count}, 32'd8);
    rd(5'd31, rv);
    chk("f_rd31", {24'd0, rv}, 32'h5f);
    rd(5'd0, rv);
    chk("f_rd0", {24'd0, rv}, 32'h40);

    // Partial sprite; clear wipes overflow
    do_clear(0, cyc);
    chk("p_ovf_clr", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 6; i++) append(8'h80 + i[7:0]);
    chk("p_count", {28'd0, sprite_count}, 32'd1);
    do_clear(0, cyc);
    chk("p_cycles", cyc, 32);
    chk("p_count0", {28'd0, sprite_count}, 32'd0);
    chk("p_ovf0", {31'd0, overflow}, 32'd0);

    // Restart at busy cycle 10, append attempted mid-clear
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (9) tick();
    chk("rs_busy10", {31'd0, busy}, 32'd1);
    do_clear(5, cyc);
    chk("rs_cycles", cyc, 32);
    chk("rs_count", {28'd0, sprite_count}, 32'd0);
    rd(5'd0, rv);
    chk("rs_rd0", {24'd0, rv}, 32'hff);
    append(8'h77);
    rd(5'd0, rv);
    chk("rs_ptr0", {24'd0, rv}, 32'h77);

    // Reset aborts a clear at busy cycle 5
    do_clear(0, cyc);
    for (int i = 0; i < 32; i++) append(8'h40 + i[7:0]);
    rd_addr = 5'd20;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_count", {28'd0, sprite_count}, 32'd0);
    chk("ar_rdata", {24'd0, rd_data}, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("ar_busy_after", {31'd0, busy}, 32'd0);
    rd(5'd20, rv);
    chk("ar_rd20", {24'd0, rv}, 32'h54);
    rd(5'd0, rv);
    chk("ar_rd0", {24'd0, rv}, 32'hff);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
